// File: rtl/mc_datapath.sv
// mc_datapath: multi-cycle datapath. Each instruction walks through
// FETCH/DECODE/EXEC/MEM/WB. Instruction fetch and data access share a single
// memory port that uses a req/ready handshake. Control signals come from an
// external decoder, which decodes combinationally from the held `instr`.
//
// Ports
//   clk, reset            clock; asynchronous active-high reset
//   mem_req/we/addr/wdata memory request (we, addr and wdata are qualified by mem_req)
//   mem_rdata, mem_ready  fetch/load data and completion strobe
//   regWrite..jump        decoder controls, sampled in DECODE..WB
//   rs1, rs2, rd          register indices
//   ALUControl, imm       ALU op and sign-extended immediate
//   instr, pc, state      latched instruction, current PC, FSM state
//   retire                high on the final cycle of each instruction
//   cycle_cnt/instret_cnt performance counters
//
// Build option: define PERF_CNT_EN to implement the performance counters.
// When it is undefined, both counter outputs are tied to zero.
//
// state  | meaning
// FETCH  | request instruction at pc, wait for mem_ready
// DECODE | read register operands into A/B
// EXEC   | ALU result into ALUOut, latch zero flag
// MEM    | load/store at ALUOut, wait for mem_ready
// WB     | register write (ALU, MDR or link), retire
module mc_datapath #(
  parameter int                WORD_W   = 32,
  parameter int                REG_N    = 32,
  parameter logic [WORD_W-1:0] RESET_PC = '0
) (
  input  logic                      clk,
  input  logic                      reset,
  output logic                      mem_req,
  output logic                      mem_we,
  output logic [WORD_W-1:0]         mem_addr,
  output logic [WORD_W-1:0]         mem_wdata,
  input  logic [WORD_W-1:0]         mem_rdata,
  input  logic                      mem_ready,
  input  logic                      regWrite,
  input  logic                      memWrite,
  input  logic                      memRead,
  input  logic                      ALUSrc,
  input  logic                      mem2reg,
  input  logic                      branch,
  input  logic                      jump,
  input  logic [$clog2(REG_N)-1:0]  rs1,
  input  logic [$clog2(REG_N)-1:0]  rs2,
  input  logic [$clog2(REG_N)-1:0]  rd,
  input  logic [2:0]                ALUControl,
  input  logic [WORD_W-1:0]         imm,
  output logic [WORD_W-1:0]         instr,
  output logic [WORD_W-1:0]         pc,
  output logic [2:0]                state,
  output logic                      retire,
  output logic [31:0]               cycle_cnt,
  output logic [31:0]               instret_cnt
);

  localparam int SH_W = $clog2(WORD_W);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4
  } state_t;

  state_t st, st_nx;

  logic [WORD_W-1:0] rf [REG_N];
  logic [WORD_W-1:0] a_q, b_q, alu_q, mdr_q, instr_q, pc_q;
  logic              zero_q;

  logic [WORD_W-1:0] op2, alu_res, pc_plus4, pc_next;
  logic [SH_W-1:0]   shamt;
  logic              alu_zero, mem_op, is_load, wb_need, take_zero, retire_c;

  assign op2      = ALUSrc ? imm : b_q;
  assign shamt    = op2[SH_W-1:0];
  assign alu_zero = (alu_res == '0);

  always_comb begin
    alu_res = '0;
    case (ALUControl)
      3'd0: alu_res = a_q + op2;
      3'd1: alu_res = a_q - op2;
      3'd2: alu_res = a_q & op2;
      3'd3: alu_res = a_q | op2;
      3'd4: alu_res = a_q ^ op2;
      3'd5: alu_res = {{(WORD_W-1){1'b0}}, ($signed(a_q) < $signed(op2))};
      3'd6: alu_res = a_q << shamt;
      default: alu_res = a_q >> shamt;
    endcase
  end

  // A store wins over a load when both are requested.
  assign mem_op  = memRead | memWrite;
  assign is_load = memRead & ~memWrite;
  assign wb_need = regWrite | jump;

  // A branch that retires in EXEC needs the zero flag being computed in the
  // same cycle. In later states the latched copy is used.
  assign take_zero = (st == S_EXEC) ? alu_zero : zero_q;
  assign pc_plus4  = pc_q + WORD_W'(4);
  assign pc_next   = (jump | (branch & take_zero)) ? pc_q + imm : pc_plus4;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) st <= S_FETCH;
    else       st <= st_nx;
  end

  always_comb begin
    st_nx    = st;
    retire_c = 1'b0;
    case (st)
      S_FETCH:  if (mem_ready) st_nx = S_DECODE;
      S_DECODE: st_nx = S_EXEC;
      S_EXEC: begin
        if (mem_op)       st_nx = S_MEM;
        else if (wb_need) st_nx = S_WB;
        else begin
          retire_c = 1'b1;
          st_nx    = S_FETCH;
        end
      end
      S_MEM: begin
        if (mem_ready) begin
          if (is_load) st_nx = S_WB;
          else begin
            retire_c = 1'b1;
            st_nx    = S_FETCH;
          end
        end
      end
      S_WB: begin
        retire_c = 1'b1;
        st_nx    = S_FETCH;
      end
      default: st_nx = S_FETCH;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      a_q     <= '0;
      b_q     <= '0;
      alu_q   <= '0;
      mdr_q   <= '0;
      zero_q  <= 1'b0;
      instr_q <= '0;
      pc_q    <= RESET_PC;
      for (int i = 0; i < REG_N; i++) rf[i] <= '0;
    end else begin
      case (st)
        S_FETCH:  if (mem_ready) instr_q <= mem_rdata;
        S_DECODE: begin
          a_q <= (rs1 == '0) ? '0 : rf[rs1];
          b_q <= (rs2 == '0) ? '0 : rf[rs2];
        end
        S_EXEC: begin
          alu_q  <= alu_res;
          zero_q <= alu_zero;
        end
        S_MEM:    if (mem_ready && is_load) mdr_q <= mem_rdata;
        S_WB: begin
          if (wb_need && (rd != '0))
            rf[rd] <= jump ? pc_plus4 : (mem2reg ? mdr_q : alu_q);
        end
        default: ;
      endcase
      if (retire_c) pc_q <= pc_next;
    end
  end

  // The request is gated by reset so that an in-flight access is dropped
  // the moment reset is asserted.
  assign mem_req   = ~reset & ((st == S_FETCH) | (st == S_MEM));
  assign mem_we    = mem_req & (st == S_MEM) & memWrite;
  assign mem_addr  = (st == S_MEM) ? alu_q : pc_q;
  assign mem_wdata = b_q;

  assign instr  = instr_q;
  assign pc     = pc_q;
  assign state  = st;
  assign retire = retire_c;

`ifdef PERF_CNT_EN
  logic [31:0] cyc_q, ret_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cyc_q <= '0;
      ret_q <= '0;
    end else begin
      cyc_q <= cyc_q + 32'd1;
      if (retire_c) ret_q <= ret_q + 32'd1;
    end
  end

  assign cycle_cnt   = cyc_q;
  assign instret_cnt = ret_q;
`else
  assign cycle_cnt   = '0;
  assign instret_cnt = '0;
`endif

endmodule
